// File: rtl/alu_pkg.sv
// Shared ALU issue-stage definitions: widths, ALU funct codes, MIPS encodings, decoded-op payload.
package alu_pkg;

    localparam int unsigned NREG  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;

    // ALU-internal funct codes
    localparam logic [5:0] FUNCT_ADDU = 6'b001001;
    localparam logic [5:0] FUNCT_SUBU = 6'b001010;
    localparam logic [5:0] FUNCT_SLL  = 6'b100001;
    localparam logic [5:0] FUNCT_SLLV = 6'b110101;
    localparam logic [5:0] FUNCT_SLTI = 6'b101010;

    // MIPS opcode / function-field encodings
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_SLTI    = 6'b001010;
    localparam logic [5:0] FN_ADDU    = 6'b100001;
    localparam logic [5:0] FN_SUBU    = 6'b100011;
    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_SLLV    = 6'b000100;

    typedef enum logic {D1_RS, D1_RT} sel_d1_e;
    typedef enum logic [1:0] {D2_RT, D2_RS, D2_ZERO, D2_IMM} sel_d2_e;

    typedef struct packed {
        logic             legal;
        logic [5:0]       funct;
        logic             use_rs;
        logic             use_rt;
        sel_d1_e          sel_d1;
        sel_d2_e          sel_d2;
        logic [REG_W-1:0] rd;
    } dec_op_t;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
        return {{(XLEN-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decoder: MIPS instruction word -> decoded ALU op.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_op_t     dec_c
);

    logic [5:0] op;
    logic [5:0] fn;
    logic       unused_fields;

    assign op            = instr[31:26];
    assign fn            = instr[5:0];
    assign unused_fields = ^{instr[25:21], instr[10:6]};

    // Map supported opcodes onto funct code, operand sources and destination
    always_comb begin
        dec_c        = '0;
        dec_c.sel_d1 = D1_RS;
        dec_c.sel_d2 = D2_ZERO;
        if (op == OP_SPECIAL) begin
            case (fn)
                FN_ADDU, FN_SUBU: begin
                    dec_c.legal  = 1'b1;
                    dec_c.funct  = (fn == FN_ADDU) ? FUNCT_ADDU : FUNCT_SUBU;
                    dec_c.use_rs = 1'b1;
                    dec_c.use_rt = 1'b1;
                    dec_c.sel_d1 = D1_RS;
                    dec_c.sel_d2 = D2_RT;
                    dec_c.rd     = instr[15:11];
                end
                FN_SLL: begin
                    dec_c.legal  = 1'b1;
                    dec_c.funct  = FUNCT_SLL;
                    dec_c.use_rt = 1'b1;
                    dec_c.sel_d1 = D1_RT;
                    dec_c.sel_d2 = D2_ZERO;
                    dec_c.rd     = instr[15:11];
                end
                FN_SLLV: begin
                    dec_c.legal  = 1'b1;
                    dec_c.funct  = FUNCT_SLLV;
                    dec_c.use_rs = 1'b1;
                    dec_c.use_rt = 1'b1;
                    dec_c.sel_d1 = D1_RT;
                    dec_c.sel_d2 = D2_RS;
                    dec_c.rd     = instr[15:11];
                end
                default: ;
            endcase
        end else if (op == OP_SLTI) begin
            dec_c.legal  = 1'b1;
            dec_c.funct  = FUNCT_SLTI;
            dec_c.use_rs = 1'b1;
            dec_c.sel_d1 = D1_RS;
            dec_c.sel_d2 = D2_IMM;
            dec_c.rd     = instr[20:16];
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, busy-scoreboard hazard stall, one-entry output register.
// Optional stall counter port enabled by defining ALU_ISSUE_STALL_CNT_EN.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_rs_data,
    input  logic [XLEN-1:0]  in_rt_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data1,
    output logic [XLEN-1:0]  out_data2,
    output logic [4:0]       out_shamt,
    output logic [5:0]       out_funct,
    output logic [REG_W-1:0] out_rd,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    output logic             illegal
`ifdef ALU_ISSUE_STALL_CNT_EN
    ,output logic [CNT_W-1:0] stall_cycles
`endif
);

    dec_op_t          dec;
    logic [REG_W-1:0] rs_idx;
    logic [REG_W-1:0] rt_idx;
    logic             hazard;
    logic             xfer;
    logic [XLEN-1:0]  d1_c;
    logic [XLEN-1:0]  d2_c;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  data1_q, data1_d;
    logic [XLEN-1:0]  data2_q, data2_d;
    logic [4:0]       shamt_q, shamt_d;
    logic [5:0]       funct_q, funct_d;
    logic [REG_W-1:0] rd_q, rd_d;
    logic             illegal_q, illegal_d;
    logic [NREG-1:0]  busy_q, busy_d;

    alu_ctrl_decode u_decode (
        .instr (in_instr),
        .dec_c (dec)
    );

    assign rs_idx = in_instr[25:21];
    assign rt_idx = in_instr[20:16];

    // Hazard check against registered busy bits, handshake and operand steering
    always_comb begin
        hazard   = (dec.use_rs && busy_q[rs_idx]) || (dec.use_rt && busy_q[rt_idx]);
        in_ready = !hazard && (!out_valid_q || out_ready);
        xfer     = in_valid && in_ready;
        d1_c     = (dec.sel_d1 == D1_RT) ? in_rt_data : in_rs_data;
        case (dec.sel_d2)
            D2_RT:   d2_c = in_rt_data;
            D2_RS:   d2_c = in_rs_data;
            D2_IMM:  d2_c = sext16(in_instr[15:0]);
            default: d2_c = '0;
        endcase
    end

    // Next state of output register, illegal pulse and scoreboard
    always_comb begin
        out_valid_d = out_valid_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        shamt_d     = shamt_q;
        funct_d     = funct_q;
        rd_d        = rd_q;
        illegal_d   = xfer && !dec.legal;
        busy_d      = busy_q;

        if (xfer && dec.legal) begin
            out_valid_d = 1'b1;
            data1_d     = d1_c;
            data2_d     = d2_c;
            shamt_d     = (dec.funct == FUNCT_SLL) ? in_instr[10:6] : 5'd0;
            funct_d     = dec.funct;
            rd_d        = dec.rd;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Clear on writeback first so a same-cycle issue to that register wins
        if (wb_valid && (wb_rd != '0)) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (xfer && dec.legal && (dec.rd != '0)) begin
            busy_d[dec.rd] = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data1_q     <= '0;
            data2_q     <= '0;
            shamt_q     <= '0;
            funct_q     <= '0;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
            busy_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            shamt_q     <= shamt_d;
            funct_q     <= funct_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data1 = data1_q;
    assign out_data2 = data2_q;
    assign out_shamt = shamt_q;
    assign out_funct = funct_q;
    assign out_rd    = rd_q;
    assign illegal   = illegal_q;

`ifdef ALU_ISSUE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a valid instruction is held off
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage (honours ALU_ISSUE_STALL_CNT_EN).
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_data;
    logic [31:0] in_rt_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [4:0]  out_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        illegal;
`ifdef ALU_ISSUE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    int n_checks = 0;
    int n_errors = 0;

    alu_issue_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_rs_data (in_rs_data),
        .in_rt_data (in_rt_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_shamt  (out_shamt),
        .out_funct  (out_funct),
        .out_rd     (out_rd),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
`ifdef ALU_ISSUE_STALL_CNT_EN
        .illegal    (illegal),
        .stall_cycles (stall_cycles)
`else
        .illegal    (illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_rs_data = '0;
        in_rt_data = '0;
        out_ready  = 1'b1;
        wb_valid   = 1'b0;
        wb_rd      = '0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data1", out_data1, 32'd0);
        check("rst_funct", 32'(out_funct), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_busy", dut.busy_q, 32'd0);
        tick;
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: ADDU r3 = r1 + r2
        in_valid = 1'b1; in_instr = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'b100001);
        in_rs_data = 32'd5; in_rt_data = 32'd7;
        tick;
        in_valid = 1'b0;
        check("addu_valid", 32'(out_valid), 32'd1);
        check("addu_funct", 32'(out_funct), 32'h09);
        check("addu_d1", out_data1, 32'd5);
        check("addu_d2", out_data2, 32'd7);
        check("addu_rd", 32'(out_rd), 32'd3);
        check("addu_shamt", 32'(out_shamt), 32'd0);
        check("addu_busy", dut.busy_q, 32'h0000_0008);
        wb_valid = 1'b1; wb_rd = 5'd3;
        tick;
        wb_valid = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("wb_clear", dut.busy_q, 32'd0);

        // 2: SLL r4 = r2 << 3, then SLTI r5 = (r1 < -1)
        in_valid = 1'b1; in_instr = r_type(5'd0, 5'd2, 5'd4, 5'd3, 6'b000000);
        in_rs_data = 32'hDEAD_BEEF; in_rt_data = 32'h1;
        tick;
        check("sll_d1", out_data1, 32'h1);
        check("sll_d2", out_data2, 32'h0);
        check("sll_shamt", 32'(out_shamt), 32'd3);
        check("sll_funct", 32'(out_funct), 32'h21);
        check("sll_rd", 32'(out_rd), 32'd4);
        in_instr = i_type(6'b001010, 5'd1, 5'd5, 16'hFFFF);
        in_rs_data = 32'd5; in_rt_data = 32'h1234;
        #1;
        check("slti_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        check("slti_d1", out_data1, 32'd5);
        check("slti_d2", out_data2, 32'hFFFF_FFFF);
        check("slti_rd", 32'(out_rd), 32'd5);
        check("slti_funct", 32'(out_funct), 32'h2A);
        check("slti_shamt", 32'(out_shamt), 32'd0);
        check("slti_busy", dut.busy_q, 32'h0000_0030);
        wb_valid = 1'b1; wb_rd = 5'd4;
        tick;
        wb_rd = 5'd5;
        tick;
        wb_valid = 1'b0;
        check("t2_busy_clear", dut.busy_q, 32'd0);

        // 3: ADDU r3, then SUBU r6 = r3 - r1 stalls until after writeback of r3
        in_valid = 1'b1; in_instr = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'b100001);
        in_rs_data = 32'd1; in_rt_data = 32'd2;
        tick;
        in_instr = r_type(5'd3, 5'd1, 5'd6, 5'd0, 6'b100011);
        in_rs_data = 32'd20; in_rt_data = 32'd8;
        #1;
        check("haz_ready_c1", 32'(in_ready), 32'd0);
        tick;
        check("haz_ready_c2", 32'(in_ready), 32'd0);
        tick;
        wb_valid = 1'b1; wb_rd = 5'd3;
        #1;
        check("haz_ready_wb", 32'(in_ready), 32'd0);
        tick;
        wb_valid = 1'b0;
        #1;
        check("haz_ready_after", 32'(in_ready), 32'd1);
        tick;
        check("subu_valid", 32'(out_valid), 32'd1);
        check("subu_funct", 32'(out_funct), 32'h0A);
        check("subu_d1", out_data1, 32'd20);
        check("subu_d2", out_data2, 32'd8);
        check("subu_rd", 32'(out_rd), 32'd6);
`ifdef ALU_ISSUE_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cycles), 32'd3);
`endif

        // 4: backpressure holds SUBU, then next op loads without a bubble
        out_ready = 1'b0;
        in_instr = r_type(5'd1, 5'd2, 5'd7, 5'd0, 6'b100001);
        in_rs_data = 32'd1; in_rt_data = 32'd2;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_d1", out_data1, 32'd20);
            check("bp_funct", 32'(out_funct), 32'h0A);
            tick;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_d1", out_data1, 32'd1);
        check("bp_next_d2", out_data2, 32'd2);
        check("bp_next_rd", 32'(out_rd), 32'd7);
        tick;
        check("bp_drain", 32'(out_valid), 32'd0);

        // 5: illegal instruction is dropped with a one-cycle pulse
        in_valid = 1'b1; in_instr = 32'hFC00_0000;
        #1;
        check("ill_ready", 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        check("ill_pulse", 32'(illegal), 32'd1);
        check("ill_out_valid", 32'(out_valid), 32'd0);
        check("ill_busy", dut.busy_q, 32'h0000_00C0);
        tick;
        check("ill_pulse_end", 32'(illegal), 32'd0);

        // 6: asynchronous reset mid-transfer
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'b100001);
        tick;
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_busy", dut.busy_q, 32'h0000_00C8);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", dut.busy_q, 32'd0);
        check("mid_rst_rd", 32'(out_rd), 32'd0);
`ifdef ALU_ISSUE_STALL_CNT_EN
        check("mid_rst_stall", 32'(stall_cycles), 32'd0);
`endif
        tick;
        rst = 1'b0;
        out_ready = 1'b1;

        // r0 destination never becomes busy
        in_valid = 1'b1; in_instr = r_type(5'd1, 5'd2, 5'd0, 5'd0, 6'b100001);
        tick;
        check("r0_valid", 32'(out_valid), 32'd1);
        check("r0_busy", dut.busy_q, 32'd0);

        // same-cycle writeback and issue to r8: set wins
        in_instr = r_type(5'd1, 5'd2, 5'd8, 5'd0, 6'b000100);
        in_rs_data = 32'd4; in_rt_data = 32'd9;
        wb_valid = 1'b1; wb_rd = 5'd8;
        tick;
        in_valid = 1'b0; wb_valid = 1'b0;
        check("set_wins_busy", dut.busy_q, 32'h0000_0100);
        check("sllv_funct", 32'(out_funct), 32'h35);
        check("sllv_d1", out_data1, 32'd9);
        check("sllv_d2", out_data2, 32'd4);
        tick;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
